// File: rtl/cache_fill_fsm.sv
// Cache miss-fill controller: streams one 8-word block from pipelined memory into
// the cache data array, then writes the tag once the last word lands.
module cache_fill_fsm #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int INDEX_W  = 7,
    parameter int OFFSET_W = 4,
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    input  logic [DATA_W-1:0] memory_data,
    output logic              fsm_busy,
    output logic              memory_read,
    output logic [ADDR_W-1:0] memory_address,
    output logic [INDEX_W-1:0] set_index,
    output logic [7:0]        word_sel,
    output logic              write_data_array,
    output logic              write_tag_array,
    output logic [TAG_W-1:0]  tag_out
);

    localparam logic [3:0] WORDS = 4'd8;
    localparam logic [ADDR_W-1:0] BLOCK_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [3:0]        req_cnt, req_cnt_next;
    logic [3:0]        rcv_cnt, rcv_cnt_next;
    logic [ADDR_W-1:0] base_addr, base_addr_next;

    // Returned data goes straight from memory to the data array; this block only strobes.
    logic unused_data;
    assign unused_data = ^memory_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_cnt   <= 4'd0;
            rcv_cnt   <= 4'd0;
            base_addr <= '0;
        end else begin
            state     <= state_next;
            req_cnt   <= req_cnt_next;
            rcv_cnt   <= rcv_cnt_next;
            base_addr <= base_addr_next;
        end
    end

    always_comb begin
        state_next       = state;
        req_cnt_next     = req_cnt;
        rcv_cnt_next     = rcv_cnt;
        base_addr_next   = base_addr;
        fsm_busy         = 1'b0;
        memory_read      = 1'b0;
        memory_address   = '0;
        word_sel         = 8'h00;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        set_index        = base_addr[OFFSET_W +: INDEX_W];
        tag_out          = base_addr[ADDR_W-1 -: TAG_W];

        case (state)
            IDLE: begin
                if (miss_detected) begin
                    base_addr_next = miss_address & BLOCK_MASK;
                    req_cnt_next   = 4'd0;
                    rcv_cnt_next   = 4'd0;
                    state_next     = FILL;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                // Requests are issued back to back regardless of how returns trickle in.
                if (req_cnt < WORDS) begin
                    memory_read    = 1'b1;
                    memory_address = base_addr + ADDR_W'({req_cnt, 1'b0});
                    req_cnt_next   = req_cnt + 4'd1;
                end
                // A return only counts when a read is actually outstanding.
                if (memory_data_valid && (rcv_cnt < req_cnt)) begin
                    write_data_array = 1'b1;
                    word_sel         = 8'b0000_0001 << rcv_cnt[2:0];
                    rcv_cnt_next     = rcv_cnt + 4'd1;
                    if (rcv_cnt == WORDS - 4'd1) begin
                        write_tag_array = 1'b1;
                        state_next      = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: every cycle compares all outputs, packed into
// one vector, against hand-derived expectations.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'h0000;
    logic        memory_data_valid = 1'b0;
    logic [15:0] memory_data = 16'h0000;
    logic        fsm_busy;
    logic        memory_read;
    logic [15:0] memory_address;
    logic [6:0]  set_index;
    logic [7:0]  word_sel;
    logic        write_data_array;
    logic        write_tag_array;
    logic [4:0]  tag_out;

    int errors = 0;
    int checks = 0;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .memory_read       (memory_read),
        .memory_address    (memory_address),
        .set_index         (set_index),
        .word_sel          (word_sel),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .tag_out           (tag_out)
    );

    always #5 clk = ~clk;

    // Layout: busy, read, address, set, word_sel, data strobe, tag strobe, tag.
    function automatic logic [39:0] expv(input logic busy, input logic rd,
                                         input logic [15:0] addr, input logic [6:0] set,
                                         input logic [7:0] ws, input logic wda,
                                         input logic wta, input logic [4:0] tag);
        return {busy, rd, addr, set, ws, wda, wta, tag};
    endfunction

    task automatic applyStimulus(input logic r, input logic m, input logic [15:0] a,
                                 input logic v);
        @(negedge clk);
        rst               = r;
        miss_detected     = m;
        miss_address      = a;
        memory_data_valid = v;
        memory_data       = memory_data + 16'h0101;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [39:0] expected);
        logic [39:0] observed;
        observed = {fsm_busy, memory_read, memory_address, set_index, word_sel,
                    write_data_array, write_tag_array, tag_out};
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
        end
    endtask

    initial begin
        // Two reset cycles, then valid in IDLE with no miss.
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("reset c1", 40'h0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("reset c2", 40'h0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("idle valid ignored", 40'h0);

        // Miss at 0x1234, memory latency 4: returns on FILL cycles 5..12.
        applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0);
        checkOutput("l4 miss cycle", 40'h0);
        for (int c = 1; c <= 12; c++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, c >= 5);
            checkOutput($sformatf("l4 c%0d", c),
                        expv(1'b1, c <= 8, (c <= 8) ? 16'h1230 + 16'(2 * (c - 1)) : 16'h0000,
                             7'h23, (c >= 5) ? 8'(1 << (c - 5)) : 8'h00,
                             c >= 5, c == 12, 5'h02));
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("l4 done", expv(1'b0, 1'b0, 16'h0, 7'h23, 8'h00, 1'b0, 1'b0, 5'h02));

        // Miss at 0x4C88, latency 1, with a second miss at 0xFFF0 held during the fill.
        applyStimulus(1'b0, 1'b1, 16'h4C88, 1'b0);
        checkOutput("remiss miss cycle", expv(1'b0, 1'b0, 16'h0, 7'h23, 8'h00, 1'b0, 1'b0, 5'h02));
        for (int c = 1; c <= 9; c++) begin
            applyStimulus(1'b0, (c >= 2) && (c <= 5), 16'hFFF0, c >= 2);
            checkOutput($sformatf("remiss c%0d", c),
                        expv(1'b1, c <= 8, (c <= 8) ? 16'h4C80 + 16'(2 * (c - 1)) : 16'h0000,
                             7'h48, (c >= 2) ? 8'(1 << (c - 2)) : 8'h00,
                             c >= 2, c == 9, 5'h09));
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("remiss done", expv(1'b0, 1'b0, 16'h0, 7'h48, 8'h00, 1'b0, 1'b0, 5'h09));

        // Miss at 0x2468, data valid only on even FILL cycles.
        applyStimulus(1'b0, 1'b1, 16'h2468, 1'b0);
        checkOutput("gaps miss cycle", expv(1'b0, 1'b0, 16'h0, 7'h48, 8'h00, 1'b0, 1'b0, 5'h09));
        for (int c = 1; c <= 16; c++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, (c % 2) == 0);
            checkOutput($sformatf("gaps c%0d", c),
                        expv(1'b1, c <= 8, (c <= 8) ? 16'h2460 + 16'(2 * (c - 1)) : 16'h0000,
                             7'h46, ((c % 2) == 0) ? 8'(1 << (c / 2 - 1)) : 8'h00,
                             (c % 2) == 0, c == 16, 5'h04));
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("gaps done", expv(1'b0, 1'b0, 16'h0, 7'h46, 8'h00, 1'b0, 1'b0, 5'h04));

        // Miss at 0xABCD, three words land, then reset abandons the block.
        applyStimulus(1'b0, 1'b1, 16'hABCD, 1'b0);
        checkOutput("abort miss cycle", expv(1'b0, 1'b0, 16'h0, 7'h46, 8'h00, 1'b0, 1'b0, 5'h04));
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, c >= 2);
            checkOutput($sformatf("abort c%0d", c),
                        expv(1'b1, 1'b1, 16'hABC0 + 16'(2 * (c - 1)), 7'h3C,
                             (c >= 2) ? 8'(1 << (c - 2)) : 8'h00, c >= 2, 1'b0, 5'h15));
        end
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("abort rst cycle", expv(1'b1, 1'b1, 16'hABC8, 7'h3C, 8'h00, 1'b0, 1'b0, 5'h15));

        // New miss at 0x0000 with valid held high from the miss cycle onward.
        applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1);
        checkOutput("zero miss cycle", 40'h0);
        for (int c = 1; c <= 9; c++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
            checkOutput($sformatf("zero c%0d", c),
                        expv(1'b1, c <= 8, (c <= 8) ? 16'(2 * (c - 1)) : 16'h0000,
                             7'h00, (c >= 2) ? 8'(1 << (c - 2)) : 8'h00,
                             c >= 2, c == 9, 5'h00));
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("zero done", 40'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
